// File: rtl/ay_bus_seq.sv
// ay_bus_seq: sequences one AY-3-8910 style register access
// (address latch, gap, write or read phase, gap, ack) per request.
//
// Parameters:
//   PHASE_CYC  cycles per active bus phase (1..15)
//   GAP_CYC    cycles per inactive gap (1..15)
//
// Ports:
//   clk, rst_n          clock, async active-low reset
//   req                 request, sampled only while idle
//   req_wr              1 = write, 0 = read
//   req_addr, req_data  register number and write data
//   ack                 one-cycle completion pulse
//   busy                high while a transaction is in flight
//   rd_data             result of the last completed read
//   ay_bdir/bc1/bc2     AY bus control lines
//   ay_da_out/ay_da_oe  AY data bus drive value and enable
//   ay_da_in            AY data bus read value
//
// Build option: define AY_READBACK_EN to include read support.
// Without it every request is a write and rd_data is 8'h00.

module ay_bus_seq #(
    parameter int unsigned PHASE_CYC = 4,
    parameter int unsigned GAP_CYC   = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       req,
    input  logic       req_wr,
    input  logic [3:0] req_addr,
    input  logic [7:0] req_data,
    output logic       ack,
    output logic       busy,
    output logic [7:0] rd_data,
    output logic       ay_bdir,
    output logic       ay_bc1,
    output logic       ay_bc2,
    output logic [7:0] ay_da_out,
    output logic       ay_da_oe,
    input  logic [7:0] ay_da_in
);

    localparam logic [3:0] PH_LD = 4'(PHASE_CYC - 1);
    localparam logic [3:0] GP_LD = 4'(GAP_CYC - 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_ADDR  = 3'd1,
        S_GAP1  = 3'd2,
        S_WRITE = 3'd3,
        S_GAP2  = 3'd4,
        S_DONE  = 3'd5
`ifdef AY_READBACK_EN
        ,
        S_READ  = 3'd6
`endif
    } state_t;

    state_t     state_q, state_d;
    logic [3:0] cnt_q, cnt_d;
    logic [3:0] addr_q, addr_d;
    logic [7:0] data_q, data_d;

    logic       bdir_q, bdir_d;
    logic       bc1_q, bc1_d;
    logic       bc2_q, bc2_d;
    logic       oe_q, oe_d;
    logic [7:0] da_q, da_d;
    logic       ack_q, ack_d;
    logic       busy_q, busy_d;

    logic       last_cyc;
    logic       is_wr;

    assign last_cyc = (cnt_q == 4'd0);

`ifdef AY_READBACK_EN
    logic       wr_q, wr_d;
    logic [7:0] rd_q, rd_d;

    assign is_wr = wr_q;
`else
    logic unused_ok;

    // Read path is compiled out, so these inputs have no effect.
    assign unused_ok = ^{req_wr, ay_da_in};
    assign is_wr     = 1'b1;
`endif

    // Next state, counter and captured request
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        data_d  = data_q;
`ifdef AY_READBACK_EN
        wr_d    = wr_q;
`endif
        unique case (state_q)
            S_IDLE: begin
                cnt_d = 4'd0;
                if (req) begin
                    state_d = S_ADDR;
                    cnt_d   = PH_LD;
                    addr_d  = req_addr;
                    data_d  = req_data;
`ifdef AY_READBACK_EN
                    wr_d    = req_wr;
`endif
                end
            end
            S_ADDR: begin
                cnt_d = cnt_q - 4'd1;
                if (last_cyc) begin
                    state_d = S_GAP1;
                    cnt_d   = GP_LD;
                end
            end
            S_GAP1: begin
                cnt_d = cnt_q - 4'd1;
                if (last_cyc) begin
                    cnt_d = PH_LD;
`ifdef AY_READBACK_EN
                    state_d = is_wr ? S_WRITE : S_READ;
`else
                    state_d = S_WRITE;
`endif
                end
            end
            S_WRITE: begin
                cnt_d = cnt_q - 4'd1;
                if (last_cyc) begin
                    state_d = S_GAP2;
                    cnt_d   = GP_LD;
                end
            end
`ifdef AY_READBACK_EN
            S_READ: begin
                cnt_d = cnt_q - 4'd1;
                if (last_cyc) begin
                    state_d = S_GAP2;
                    cnt_d   = GP_LD;
                end
            end
`endif
            S_GAP2: begin
                cnt_d = cnt_q - 4'd1;
                if (last_cyc) begin
                    state_d = S_DONE;
                    cnt_d   = 4'd0;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
                cnt_d   = 4'd0;
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = 4'd0;
            end
        endcase
    end

    // Outputs are decoded from the next state so they are
    // registered alongside it and line up with the state.
    always_comb begin
        bdir_d = 1'b0;
        bc2_d  = 1'b1;
        bc1_d  = 1'b0;
        oe_d   = 1'b0;
        da_d   = da_q;
        ack_d  = 1'b0;
        busy_d = (state_d != S_IDLE);
        unique case (state_d)
            S_ADDR: begin
                bdir_d = 1'b1;
                bc1_d  = 1'b1;
                oe_d   = 1'b1;
                da_d   = {4'b0000, addr_d};
            end
            S_WRITE: begin
                bdir_d = 1'b1;
                oe_d   = 1'b1;
                da_d   = data_d;
            end
`ifdef AY_READBACK_EN
            S_READ: begin
                bc1_d = 1'b1;
            end
`endif
            S_DONE: begin
                ack_d = 1'b1;
            end
            default: begin
            end
        endcase
    end

`ifdef AY_READBACK_EN
    // Bus value is taken on the edge closing the final READ cycle.
    always_comb begin
        rd_d = rd_q;
        if (state_q == S_READ && last_cyc) begin
            rd_d = ay_da_in;
        end
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= 4'd0;
            addr_q  <= 4'd0;
            data_q  <= 8'h00;
            bdir_q  <= 1'b0;
            bc1_q   <= 1'b0;
            bc2_q   <= 1'b1;
            oe_q    <= 1'b0;
            da_q    <= 8'h00;
            ack_q   <= 1'b0;
            busy_q  <= 1'b0;
`ifdef AY_READBACK_EN
            wr_q    <= 1'b0;
            rd_q    <= 8'h00;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            bdir_q  <= bdir_d;
            bc1_q   <= bc1_d;
            bc2_q   <= bc2_d;
            oe_q    <= oe_d;
            da_q    <= da_d;
            ack_q   <= ack_d;
            busy_q  <= busy_d;
`ifdef AY_READBACK_EN
            wr_q    <= wr_d;
            rd_q    <= rd_d;
`endif
        end
    end

    assign ay_bdir   = bdir_q;
    assign ay_bc1    = bc1_q;
    assign ay_bc2    = bc2_q;
    assign ay_da_oe  = oe_q;
    assign ay_da_out = da_q;
    assign ack       = ack_q;
    assign busy      = busy_q;

`ifdef AY_READBACK_EN
    assign rd_data = rd_q;
`else
    assign rd_data = 8'h00;
`endif

endmodule
